mac_cyv_half_seq: RTL and testbench

Sequencer for the half-precision fixed-point MAC pipeline (`mac_cyv_half` family: fp16 operands converted to 20-bit fixed with radix 10, 32-bit accumulator with radix 20, 4-cycle latency). It computes one N-element dot product plus bias per `start` request. Operand pairs are streamed from a 1-cycle-latency operand RAM. Four interleaved partial sums are recirculated through the MAC's `c` input, so one element issues every cycle. The four lane partials are then reduced in an internal 32-bit adder.

---
 rtl/mac_cyv_half_seq.sv | 161 ++++++++++++++++
 tb/tb_mac_cyv_half_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mac_cyv_half_seq.sv
// Dot-product sequencer for the mac_cyv_half MAC: streams operands, recirculates
// MAC_LAT interleaved lane partials, then reduces them. Optional: `MAC_SEQ_SAT_EN.
module mac_cyv_half_seq #(
  parameter int MAC_LAT = 4,
  parameter int LEN_W   = 10
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [31:0]      bias,
  output logic             busy,
  output logic             done,
  output logic [31:0]      result,
  output logic             ovf,
  output logic             rd_en,
  output logic [LEN_W-1:0] rd_addr,
  input  logic [15:0]      rd_a,
  input  logic [15:0]      rd_b,
  output logic             mac_en,
  output logic [15:0]      mac_a,
  output logic [15:0]      mac_b,
  output logic [31:0]      mac_c,
  input  logic [31:0]      mac_q
);

  localparam int CNT_W = LEN_W + 2;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] t_q, t_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [31:0]      bias_q, bias_d;
  logic [31:0]      acc_q, acc_d;
  logic             sticky_q, sticky_d;
  logic [31:0]      result_q, result_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [CNT_W-1:0] lenExt, padLen, kIdx;
  logic [31:0]      sumRaw, sumStep;
  logic             stepOvf;

  assign lenExt = CNT_W'(len_q);
  assign padLen = (lenExt < CNT_W'(MAC_LAT)) ? CNT_W'(MAC_LAT) : lenExt;
  assign kIdx   = t_q - CNT_W'(1);

  // Reduction step: signed add with overflow detect, optional saturation
  assign sumRaw  = acc_q + mac_q;
  assign stepOvf = (acc_q[31] == mac_q[31]) && (sumRaw[31] != acc_q[31]);
`ifdef MAC_SEQ_SAT_EN
  assign sumStep = stepOvf ? (acc_q[31] ? 32'h8000_0000 : 32'h7FFF_FFFF) : sumRaw;
`else
  assign sumStep = sumRaw;
`endif

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q  <= IDLE;
      t_q      <= '0;
      len_q    <= '0;
      bias_q   <= '0;
      acc_q    <= '0;
      sticky_q <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      len_q    <= len_d;
      bias_q   <= bias_d;
      acc_q    <= acc_d;
      sticky_q <= sticky_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    len_d    = len_q;
    bias_d   = bias_q;
    acc_d    = acc_q;
    sticky_d = sticky_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = ISSUE;
          t_d      = '0;
          len_d    = len;
          bias_d   = bias;
          acc_d    = '0;
          sticky_d = 1'b0;
          busy_d   = 1'b1;
        end
      end
      ISSUE: begin
        t_d = t_q + CNT_W'(1);
        if (t_q == padLen) state_d = DRAIN;
      end
      DRAIN: begin
        t_d      = t_q + CNT_W'(1);
        acc_d    = sumStep;
        sticky_d = sticky_q | stepOvf;
        // Result and done are registered on the edge into DONE
        if (t_q == padLen + CNT_W'(MAC_LAT)) begin
          state_d  = DONE;
          result_d = sumStep;
          ovf_d    = sticky_q | stepOvf;
          done_d   = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_en   = 1'b0;
    rd_addr = '0;
    mac_en  = 1'b0;
    mac_a   = '0;
    mac_b   = '0;
    mac_c   = '0;
    if (state_q == ISSUE && t_q < lenExt) begin
      rd_en   = 1'b1;
      rd_addr = t_q[LEN_W-1:0];
    end
    if (state_q == ISSUE || state_q == DRAIN) mac_en = 1'b1;
    // Element k = t-1; lanes beyond N are zero pads so every lane gets its bias/zero seed
    if (state_q == ISSUE && t_q != '0) begin
      if (kIdx < lenExt) begin
        mac_a = rd_a;
        mac_b = rd_b;
      end
      if (kIdx == '0) mac_c = bias_q;
      else if (kIdx < CNT_W'(MAC_LAT)) mac_c = '0;
      else mac_c = mac_q;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_mac_cyv_half_seq.sv
// Directed testbench for mac_cyv_half_seq with a behavioural fp16 MAC and operand RAM.
module tb_mac_cyv_half_seq;

  localparam int MAC_LAT = 4;
  localparam int LEN_W   = 10;

  logic             clk = 1'b0;
  logic             areset;
  logic             start;
  logic [LEN_W-1:0] len;
  logic [31:0]      bias;
  logic             busy, done, ovf, rd_en, mac_en;
  logic [31:0]      result, mac_c, mac_q;
  logic [LEN_W-1:0] rd_addr;
  logic [15:0]      rd_a, rd_b, mac_a, mac_b;

  int checks = 0;
  int errors = 0;

  logic [15:0] ramA [16];
  logic [15:0] ramB [16];
  logic [31:0] pipe [MAC_LAT];

  int rdCount = 0;
  int rdExpect = 0;
  bit rdSeqBad = 0;

  mac_cyv_half_seq #(.MAC_LAT(MAC_LAT), .LEN_W(LEN_W)) dut (
    .clk(clk), .areset(areset), .start(start), .len(len), .bias(bias),
    .busy(busy), .done(done), .result(result), .ovf(ovf),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_a(rd_a), .rd_b(rd_b),
    .mac_en(mac_en), .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c), .mac_q(mac_q)
  );

  always #5 clk = ~clk;

  // fp16 normal value to fixed point with 10 fractional bits
  function automatic longint fp16ToFix(input logic [15:0] h);
    int e;
    longint mag, v;
    e = int'(h[14:10]);
    if (e == 0) return 0;
    mag = longint'({1'b1, h[9:0]});
    if (e >= 15) v = mag <<< (e - 15);
    else v = mag >>> (15 - e);
    return h[15] ? -v : v;
  endfunction

  // Free-running MAC model: q = a*b + c, MAC_LAT cycles later
  always @(posedge clk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < MAC_LAT; i++) pipe[i] <= '0;
    end else begin
      logic [63:0] prod;
      prod = 64'(fp16ToFix(mac_a) * fp16ToFix(mac_b));
      pipe[0] <= mac_c + prod[31:0];
      for (int i = 1; i < MAC_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign mac_q = pipe[MAC_LAT-1];

  always @(posedge clk or posedge areset) begin
    if (areset) begin
      rd_a <= '0;
      rd_b <= '0;
    end else if (rd_en) begin
      rd_a <= ramA[rd_addr[3:0]];
      rd_b <= ramB[rd_addr[3:0]];
    end
  end

  always @(negedge clk) begin
    if (rd_en) begin
      if (int'(rd_addr) != rdExpect) rdSeqBad <= 1'b1;
      rdExpect <= rdExpect + 1;
      rdCount  <= rdCount + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic loadRam(input logic [15:0] a, input logic [15:0] b);
    for (int i = 0; i < 16; i++) begin
      ramA[i] = a;
      ramB[i] = b;
    end
  endtask

  // Runs one operation; optionally re-pulses start mid-ISSUE. Returns start-to-done cycles.
  task automatic applyStimulus(input int n, input logic [31:0] b, input bit doubleStart, output int cycles);
    @(negedge clk);
    rdCount  = 0;
    rdExpect = 0;
    rdSeqBad = 0;
    start = 1'b1;
    len   = LEN_W'(n);
    bias  = b;
    @(negedge clk);
    start  = 1'b0;
    cycles = 1;
    while (!done && cycles < 300) begin
      if (doubleStart && cycles == 3) begin
        start = 1'b1;
        len   = LEN_W'(1);
        bias  = 32'h1234_5678;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    checkOutput("doneSeen", {31'b0, done}, 32'd1);
  endtask

  initial begin
    int cyc;
    areset = 1'b1;
    start  = 1'b0;
    len    = '0;
    bias   = '0;
    loadRam(16'h3C00, 16'h3C00);
    repeat (2) @(negedge clk);
    checkOutput("rstBusy",  {31'b0, busy},   32'd0);
    checkOutput("rstDone",  {31'b0, done},   32'd0);
    checkOutput("rstRes",   result,          32'd0);
    checkOutput("rstOvf",   {31'b0, ovf},    32'd0);
    checkOutput("rstRdEn",  {31'b0, rd_en},  32'd0);
    checkOutput("rstMacEn", {31'b0, mac_en}, 32'd0);
    checkOutput("rstMacA",  {16'b0, mac_a},  32'd0);
    checkOutput("rstMacC",  mac_c,           32'd0);
    areset = 1'b0;
    @(negedge clk);

    $display("[TB] N=1 1.0*1.0");
    applyStimulus(1, 32'h0, 1'b0, cyc);
    checkOutput("n1Res", result, 32'h0010_0000);
    checkOutput("n1Ovf", {31'b0, ovf}, 32'd0);
    checkOutput("n1Lat", 32'(cyc), 32'd10);
    checkOutput("n1Busy", {31'b0, busy}, 32'd1);
    checkOutput("n1RdCnt", 32'(rdCount), 32'd1);
    @(negedge clk);
    checkOutput("n1DonePulse", {31'b0, done}, 32'd0);
    checkOutput("n1BusyEnd", {31'b0, busy}, 32'd0);
    checkOutput("n1Held", result, 32'h0010_0000);

    $display("[TB] N=8 2.0*1.0 bias 0.5");
    loadRam(16'h4000, 16'h3C00);
    applyStimulus(8, 32'h0008_0000, 1'b0, cyc);
    checkOutput("n8Res", result, 32'h0108_0000);
    checkOutput("n8Ovf", {31'b0, ovf}, 32'd0);
    checkOutput("n8RdCnt", 32'(rdCount), 32'd8);
    checkOutput("n8RdSeq", {31'b0, rdSeqBad}, 32'd0);
    checkOutput("n8Lat", 32'(cyc), 32'd14);

    $display("[TB] N=0 bias only");
    applyStimulus(0, 32'h0001_2345, 1'b0, cyc);
    checkOutput("n0Res", result, 32'h0001_2345);
    checkOutput("n0RdCnt", 32'(rdCount), 32'd0);
    checkOutput("n0Lat", 32'(cyc), 32'd10);

    $display("[TB] N=4 32.0*24.0 reduction overflow");
    loadRam(16'h5000, 16'h4E00);
    applyStimulus(4, 32'h0, 1'b0, cyc);
`ifdef MAC_SEQ_SAT_EN
    checkOutput("ovfRes", result, 32'h7FFF_FFFF);
`else
    checkOutput("ovfRes", result, 32'hC000_0000);
`endif
    checkOutput("ovfFlag", {31'b0, ovf}, 32'd1);

    $display("[TB] start re-pulsed mid-ISSUE");
    loadRam(16'h4000, 16'h3C00);
    applyStimulus(8, 32'h0, 1'b1, cyc);
    checkOutput("dblRes", result, 32'h0100_0000);
    checkOutput("dblOvf", {31'b0, ovf}, 32'd0);
    checkOutput("dblLat", 32'(cyc), 32'd14);
    repeat (3) @(negedge clk);
    checkOutput("dblIdle", {31'b0, busy}, 32'd0);

    $display("[TB] reset during DRAIN");
    loadRam(16'h3C00, 16'h3C00);
    start = 1'b1;
    len   = LEN_W'(4);
    bias  = 32'h0;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("drnMacEn", {31'b0, mac_en}, 32'd1);
    areset = 1'b1;
    #1;
    checkOutput("arBusy",  {31'b0, busy},   32'd0);
    checkOutput("arRes",   result,          32'd0);
    checkOutput("arMacEn", {31'b0, mac_en}, 32'd0);
    checkOutput("arMacC",  mac_c,           32'd0);
    @(negedge clk);
    areset = 1'b0;
    applyStimulus(1, 32'h0, 1'b0, cyc);
    checkOutput("postRstRes", result, 32'h0010_0000);
    checkOutput("postRstLat", 32'(cyc), 32'd10);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
